// File: rtl/trng_pkg.sv
// Shared constants, state encoding and word-count helper for the TRNG refresh scheduler.
// NA/ND/NW reflect the default operand widths; instances derive their own from parameters.
package trng_pkg;

    localparam int DEF_A_WIDTH   = 64;
    localparam int DEF_D_WIDTH   = 32;
    localparam int DEF_ENT_WIDTH = 32;

    function automatic int num_words(input int width, input int ent_width);
        return width / ent_width;
    endfunction

    localparam int NA    = num_words(DEF_A_WIDTH, DEF_ENT_WIDTH);
    localparam int ND    = num_words(DEF_D_WIDTH, DEF_ENT_WIDTH);
    localparam int NW    = NA + ND;
    localparam int CNT_W = 16;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/trng_rep_test.sv
// Repetition health test: flags accepted words equal to the previous accepted word
// and trips once REP_LIMIT identical words have been seen in a row.
module trng_rep_test #(
    parameter int ENT_WIDTH = 32,
    parameter int REP_LIMIT = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic [ENT_WIDTH-1:0] i_word,
    input  logic                 i_accept,
    output logic                 o_discard,
    output logic                 o_trip
);

    localparam int RW = $clog2(REP_LIMIT) + 1;
    localparam logic [RW-1:0] TRIP_AT = RW'(REP_LIMIT - 2);

    logic [ENT_WIDTH-1:0] r_last;
    logic                 r_last_valid;
    logic [RW-1:0]        r_rep_cnt;

    // The first word after reset or clear has nothing to compare against.
    assign o_discard = i_accept && r_last_valid && (i_word == r_last);
    assign o_trip    = o_discard && (r_rep_cnt == TRIP_AT);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_last       <= '0;
            r_last_valid <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (i_accept) begin
            r_last       <= i_word;
            r_last_valid <= 1'b1;
            r_rep_cnt    <= o_discard ? r_rep_cnt + RW'(1) : '0;
        end
    end

endmodule

// File: rtl/trng_refresh_scheduler.sv
// Packs health-checked entropy words into staged A/D operands and issues a one-cycle
// dcr load strobe when a refresh is pending and a complete set is staged.
module trng_refresh_scheduler
    import trng_pkg::*;
#(
    parameter int TRNG_A_WIDTH   = DEF_A_WIDTH,
    parameter int TRNG_D_WIDTH   = DEF_D_WIDTH,
    parameter int ENT_WIDTH      = DEF_ENT_WIDTH,
    parameter int REFRESH_PERIOD = 1024,
    parameter int REP_LIMIT      = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [ENT_WIDTH-1:0]    i_ent_data,
    input  logic                    i_ent_valid,
    output logic                    o_ent_ready,
    input  logic                    i_refresh_req,
    input  logic                    i_clr_fail,
    output logic                    o_dcr,
    output logic [TRNG_A_WIDTH-1:0] o_trng_a_out,
    output logic [TRNG_D_WIDTH-1:0] o_trng_d_out,
    output logic                    o_pending,
    output logic                    o_fresh,
    output logic                    o_health_fail,
    output logic [CNT_W-1:0]        o_refresh_cnt
);

    localparam int NA_I = num_words(TRNG_A_WIDTH, ENT_WIDTH);
    localparam int ND_I = num_words(TRNG_D_WIDTH, ENT_WIDTH);
    localparam int NW_I = NA_I + ND_I;
    localparam int SW   = TRNG_A_WIDTH + TRNG_D_WIDTH;
    localparam int CW   = $clog2(NW_I + 1);
    localparam int PW   = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = (REFRESH_PERIOD > 0) ? PW'(REFRESH_PERIOD - 1) : '0;
    localparam logic [CW-1:0] LAST_WORD   = CW'(NW_I - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_word_cnt;
    logic [SW-1:0]    r_stage;
    logic             r_dcr;
    logic             r_pending;
    logic             r_health_fail;
    logic [CNT_W-1:0] r_refresh_cnt;
    logic [PW-1:0]    r_period;

    logic w_accept;
    logic w_write;
    logic w_discard;
    logic w_trip;
    logic w_expire;
    logic w_trigger;
    logic w_fire;

    assign o_ent_ready = (r_state == FILL) && i_en && !r_health_fail;
    assign w_accept    = i_ent_valid && o_ent_ready;
    assign w_write     = w_accept && !w_discard && !i_clr_fail;
    assign w_fire      = (r_state == FULL) && r_pending && i_en && !r_health_fail && !i_clr_fail;
    assign w_expire    = (REFRESH_PERIOD != 0) && (r_period == PERIOD_LAST);
    assign w_trigger   = i_en && (i_refresh_req || w_expire);

    trng_rep_test #(
        .ENT_WIDTH (ENT_WIDTH),
        .REP_LIMIT (REP_LIMIT)
    ) u_rep_test (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (i_clr_fail),
        .i_word    (i_ent_data),
        .i_accept  (w_accept),
        .o_discard (w_discard),
        .o_trip    (w_trip)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= FILL;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: if (w_write && (r_word_cnt == LAST_WORD)) w_state_next = FULL;
            FULL: if (i_clr_fail || w_fire) w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word_cnt    <= '0;
            r_stage       <= '0;
            r_dcr         <= 1'b0;
            r_pending     <= 1'b0;
            r_health_fail <= 1'b0;
            r_refresh_cnt <= '0;
            r_period      <= '0;
        end else begin
            r_dcr     <= w_fire;
            // A new trigger wins over the clear so a request during service is not lost.
            r_pending <= w_trigger || (r_pending && !w_fire);

            if (w_fire) r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);

            if (i_en) begin
                if (w_fire || w_expire) r_period <= '0;
                else                    r_period <= r_period + PW'(1);
            end

            if (i_clr_fail)  r_health_fail <= 1'b0;
            else if (w_trip) r_health_fail <= 1'b1;

            if (i_clr_fail || w_trip || w_fire) r_word_cnt <= '0;
            else if (w_write)                   r_word_cnt <= r_word_cnt + CW'(1);

            if (w_write) begin
                for (int k = 0; k < NW_I; k++) begin
                    if (r_word_cnt == CW'(k)) r_stage[k*ENT_WIDTH +: ENT_WIDTH] <= i_ent_data;
                end
            end
        end
    end

    assign o_dcr         = r_dcr;
    assign o_trng_a_out  = r_stage[TRNG_A_WIDTH-1:0];
    assign o_trng_d_out  = r_stage[SW-1:TRNG_A_WIDTH];
    assign o_pending     = r_pending;
    assign o_fresh       = (r_state == FULL);
    assign o_health_fail = r_health_fail;
    assign o_refresh_cnt = r_refresh_cnt;

endmodule

// File: tb/tb_trng_refresh_scheduler.sv
// Self-checking bench: scoreboard of expected staged sets popped on each dcr pulse,
// plus per-scenario inline checks; a second instance exercises periodic refresh.
module tb_trng_refresh_scheduler;

    typedef struct {
        logic [63:0] a;
        logic [31:0] d;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en, req, clr;
    logic [31:0] ent_data;
    logic        ent_valid, ent_ready;
    logic        dcr, pending, fresh, hf;
    logic [63:0] a_out;
    logic [31:0] d_out;
    logic [15:0] rcnt;

    logic [31:0] p_data;
    logic        p_valid, p_ready, p_dcr, p_pending, p_fresh, p_hf;
    logic [63:0] p_a;
    logic [31:0] p_d;
    logic [15:0] p_rcnt;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp_cnt = 0;
    exp_t sb[$];
    exp_t m_exp;

    always #5 clk = ~clk;

    trng_refresh_scheduler #(
        .TRNG_A_WIDTH(64), .TRNG_D_WIDTH(32), .ENT_WIDTH(32),
        .REFRESH_PERIOD(0), .REP_LIMIT(3)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_ent_data(ent_data),
        .i_ent_valid(ent_valid), .o_ent_ready(ent_ready), .i_refresh_req(req),
        .i_clr_fail(clr), .o_dcr(dcr), .o_trng_a_out(a_out), .o_trng_d_out(d_out),
        .o_pending(pending), .o_fresh(fresh), .o_health_fail(hf), .o_refresh_cnt(rcnt)
    );

    trng_refresh_scheduler #(
        .TRNG_A_WIDTH(64), .TRNG_D_WIDTH(32), .ENT_WIDTH(32),
        .REFRESH_PERIOD(16), .REP_LIMIT(3)
    ) dutp (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_ent_data(p_data),
        .i_ent_valid(p_valid), .o_ent_ready(p_ready), .i_refresh_req(1'b0),
        .i_clr_fail(1'b0), .o_dcr(p_dcr), .o_trng_a_out(p_a), .o_trng_d_out(p_d),
        .o_pending(p_pending), .o_fresh(p_fresh), .o_health_fail(p_hf), .o_refresh_cnt(p_rcnt)
    );

    // Scoreboard consumer: every dcr pulse must match the oldest expected set.
    always @(negedge clk) begin
        if (dcr === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++; n_mis++;
                $display("[TB] FAIL dcr_unexpected: got dcr=1, required no pulse at %0t", $time);
            end else begin
                m_exp = sb.pop_front();
                n_cmp++;
                if (a_out !== m_exp.a) begin n_mis++; $display("[TB] FAIL dcr_a: got %h required %h", a_out, m_exp.a); end
                n_cmp++;
                if (d_out !== m_exp.d) begin n_mis++; $display("[TB] FAIL dcr_d: got %h required %h", d_out, m_exp.d); end
                n_cmp++;
                if (rcnt !== m_exp.cnt) begin n_mis++; $display("[TB] FAIL dcr_cnt: got %0d required %0d", rcnt, m_exp.cnt); end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0;
    endtask

    task automatic push_exp(input logic [63:0] a, input logic [31:0] d);
        exp_t e;
        exp_cnt++;
        e.a = a; e.d = d; e.cnt = 16'(exp_cnt);
        sb.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] w);
        ent_data = w;
        ent_valid = 1'b1;
        #1;
        for (int n = 0; n < 20; n++) begin
            if (ent_ready === 1'b1) begin
                @(negedge clk);
                ent_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        ent_valid = 1'b0;
        n_cmp++; n_mis++;
        $display("[TB] FAIL send_word_timeout: got ent_ready=0 for word %h, required 1", w);
    endtask

    task automatic pulse_req();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin n_mis++; $display("[TB] FAIL %s_drain: got %0d sets unserved, required 0", name, sb.size()); end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (dcr !== 1'b0)      begin n_mis++; $display("[TB] FAIL reset_dcr: got %b required 0", dcr); end
        n_cmp++; if (a_out !== 64'h0)   begin n_mis++; $display("[TB] FAIL reset_a: got %h required 0", a_out); end
        n_cmp++; if (d_out !== 32'h0)   begin n_mis++; $display("[TB] FAIL reset_d: got %h required 0", d_out); end
        n_cmp++; if (pending !== 1'b0)  begin n_mis++; $display("[TB] FAIL reset_pending: got %b required 0", pending); end
        n_cmp++; if (fresh !== 1'b0)    begin n_mis++; $display("[TB] FAIL reset_fresh: got %b required 0", fresh); end
        n_cmp++; if (hf !== 1'b0)       begin n_mis++; $display("[TB] FAIL reset_hf: got %b required 0", hf); end
        n_cmp++; if (rcnt !== 16'h0)    begin n_mis++; $display("[TB] FAIL reset_cnt: got %0d required 0", rcnt); end
        n_cmp++; if (ent_ready !== 1'b1) begin n_mis++; $display("[TB] FAIL reset_ready: got %b required 1", ent_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        n_cmp++; if (fresh !== 1'b1)     begin n_mis++; $display("[TB] FAIL basic_fresh: got %b required 1", fresh); end
        n_cmp++; if (ent_ready !== 1'b0) begin n_mis++; $display("[TB] FAIL basic_ready: got %b required 0", ent_ready); end
        push_exp(64'h22222222_11111111, 32'h33333333);
        pulse_req();
        wait_drain("basic");
        n_cmp++; if (rcnt !== 16'd1)    begin n_mis++; $display("[TB] FAIL basic_cnt: got %0d required 1", rcnt); end
        n_cmp++; if (pending !== 1'b0)  begin n_mis++; $display("[TB] FAIL basic_pending: got %b required 0", pending); end
        n_cmp++; if (fresh !== 1'b0)    begin n_mis++; $display("[TB] FAIL basic_refill: got fresh=%b required 0", fresh); end
    endtask

    task automatic test_early_request();
        do_reset();
        send_word(32'h01010101);
        pulse_req();
        n_cmp++; if (pending !== 1'b1) begin n_mis++; $display("[TB] FAIL early_pending: got %b required 1", pending); end
        push_exp(64'h02020202_01010101, 32'h03030303);
        send_word(32'h02020202);
        send_word(32'h03030303);
        @(negedge clk);
        n_cmp++; if (dcr !== 1'b1)     begin n_mis++; $display("[TB] FAIL early_dcr_timing: got %b required 1", dcr); end
        wait_drain("early");
        n_cmp++; if (pending !== 1'b0) begin n_mis++; $display("[TB] FAIL early_clear: got %b required 0", pending); end
    endtask

    task automatic test_repeat_discard();
        do_reset();
        send_word(32'h0C0C0C0C);
        send_word(32'h0C0C0C0C);
        send_word(32'h0D0D0D0D);
        send_word(32'h0E0E0E0E);
        n_cmp++; if (hf !== 1'b0) begin n_mis++; $display("[TB] FAIL discard_hf: got %b required 0", hf); end
        n_cmp++; if (a_out !== 64'h0D0D0D0D_0C0C0C0C) begin n_mis++; $display("[TB] FAIL discard_a: got %h required 0d0d0d0d0c0c0c0c", a_out); end
        push_exp(64'h0D0D0D0D_0C0C0C0C, 32'h0E0E0E0E);
        pulse_req();
        wait_drain("discard");
    endtask

    task automatic test_rep_fail();
        do_reset();
        repeat (3) send_word(32'hAAAAAAAA);
        n_cmp++; if (hf !== 1'b1)        begin n_mis++; $display("[TB] FAIL repfail_hf: got %b required 1", hf); end
        n_cmp++; if (ent_ready !== 1'b0) begin n_mis++; $display("[TB] FAIL repfail_ready: got %b required 0", ent_ready); end
        n_cmp++; if (a_out !== 64'h00000000_AAAAAAAA) begin n_mis++; $display("[TB] FAIL repfail_a: got %h required 00000000aaaaaaaa", a_out); end
        pulse_req();
        repeat (4) @(negedge clk);
        n_cmp++; if (pending !== 1'b1)   begin n_mis++; $display("[TB] FAIL repfail_pending: got %b required 1", pending); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_cmp++; if (hf !== 1'b0)        begin n_mis++; $display("[TB] FAIL clrfail_hf: got %b required 0", hf); end
        n_cmp++; if (ent_ready !== 1'b1) begin n_mis++; $display("[TB] FAIL clrfail_ready: got %b required 1", ent_ready); end
        push_exp(64'h66666666_55555555, 32'h77777777);
        send_word(32'h55555555);
        send_word(32'h66666666);
        send_word(32'h77777777);
        wait_drain("clrfail");
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0;
        pulse_req();
        n_cmp++; if (pending !== 1'b0)   begin n_mis++; $display("[TB] FAIL en0_latch: got pending=%b required 0", pending); end
        n_cmp++; if (ent_ready !== 1'b0) begin n_mis++; $display("[TB] FAIL en0_ready: got %b required 0", ent_ready); end
        en = 1'b1;
        send_word(32'h21212121);
        pulse_req();
        send_word(32'h22222222);
        send_word(32'h23232323);
        en = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (dcr !== 1'b0)      begin n_mis++; $display("[TB] FAIL en0_dcr: got %b required 0", dcr); end
        n_cmp++; if (pending !== 1'b1)  begin n_mis++; $display("[TB] FAIL en0_pending: got %b required 1", pending); end
        n_cmp++; if (a_out !== 64'h22222222_21212121) begin n_mis++; $display("[TB] FAIL en0_a: got %h required 2222222221212121", a_out); end
        push_exp(64'h22222222_21212121, 32'h23232323);
        en = 1'b1;
        @(negedge clk);
        n_cmp++; if (dcr !== 1'b1)      begin n_mis++; $display("[TB] FAIL en1_dcr: got %b required 1", dcr); end
        wait_drain("enable");
    endtask

    task automatic test_reset_midfill();
        do_reset();
        send_word(32'hA1A1A1A1);
        send_word(32'hA2A2A2A2);
        n_cmp++; if (a_out !== 64'hA2A2A2A2_A1A1A1A1) begin n_mis++; $display("[TB] FAIL midfill_a: got %h required a2a2a2a2a1a1a1a1", a_out); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        n_cmp++; if (a_out !== 64'h0) begin n_mis++; $display("[TB] FAIL midfill_reset_a: got %h required 0", a_out); end
        push_exp(64'hB2B2B2B2_B1B1B1B1, 32'hB3B3B3B3);
        send_word(32'hB1B1B1B1);
        send_word(32'hB2B2B2B2);
        send_word(32'hB3B3B3B3);
        pulse_req();
        wait_drain("midfill");
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_exp(64'hC2C2C2C2_C1C1C1C1, 32'hC3C3C3C3);
        send_word(32'hC1C1C1C1);
        send_word(32'hC2C2C2C2);
        send_word(32'hC3C3C3C3);
        pulse_req();
        @(negedge clk);
        n_cmp++; if (dcr !== 1'b1) begin n_mis++; $display("[TB] FAIL b2b_dcr1: got %b required 1", dcr); end
        pulse_req();
        n_cmp++; if (pending !== 1'b1) begin n_mis++; $display("[TB] FAIL b2b_relatch: got %b required 1", pending); end
        push_exp(64'hD2D2D2D2_D1D1D1D1, 32'hD3D3D3D3);
        send_word(32'hD1D1D1D1);
        send_word(32'hD2D2D2D2);
        send_word(32'hD3D3D3D3);
        wait_drain("b2b");
        n_cmp++; if (rcnt !== 16'd2) begin n_mis++; $display("[TB] FAIL b2b_cnt: got %0d required 2", rcnt); end
    endtask

    task automatic test_periodic();
        int n_dcr;
        int last_c;
        do_reset();
        n_dcr = 0;
        last_c = -1;
        p_valid = 1'b1;
        p_data = 32'h1000;
        for (int c = 0; c <= 70; c++) begin
            @(negedge clk);
            p_data = 32'h1000 + 32'(c) + 32'd1;
            if (p_dcr === 1'b1) begin
                n_dcr++;
                n_cmp++;
                if (p_rcnt !== 16'(n_dcr)) begin n_mis++; $display("[TB] FAIL periodic_cnt: got %0d required %0d", p_rcnt, n_dcr); end
                n_cmp++;
                if (last_c < 0) begin
                    if (c < 15 || c > 17) begin n_mis++; $display("[TB] FAIL periodic_first: got cycle %0d required 15..17", c); end
                end else if ((c - last_c) < 16 || (c - last_c) > 17) begin
                    n_mis++; $display("[TB] FAIL periodic_gap: got %0d cycles required 16..17", c - last_c);
                end
                last_c = c;
            end
        end
        p_valid = 1'b0;
        n_cmp++; if (n_dcr != 4) begin n_mis++; $display("[TB] FAIL periodic_count: got %0d pulses required 4", n_dcr); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = 1'b0; clr = 1'b0;
        ent_data = '0; ent_valid = 1'b0;
        p_data = '0; p_valid = 1'b0;
        test_reset();
        test_basic();
        test_early_request();
        test_repeat_discard();
        test_rep_fail();
        test_enable();
        test_reset_midfill();
        test_back_to_back();
        test_periodic();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
